// File: rtl/miner_controller.sv
`default_nettype none
// ============================================================================
//  Module   : miner_controller
//  Brief    : Command decoder and job sequencer between the frame input
//             handler, the hash core and the byte-wide response transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module miner_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic         ih_ready,
    input  logic [7:0]   ih_command,
    input  logic [15:0]  ih_data_count,
    input  logic [255:0] ih_buffer,
    output logic         ih_data_request,
    output logic         core_start,
    output logic         core_abort,
    output logic [255:0] core_midstate,
    output logic [95:0]  core_tail,
    output logic [31:0]  core_nonce_base,
    input  logic         core_done,
    input  logic         core_found,
    input  logic [31:0]  core_nonce,
    output logic         tx_valid,
    output logic [7:0]   tx_byte,
    input  logic         tx_ready,
    output logic         busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DECODE = 2'd1;
    localparam logic [1:0] c_RUN    = 2'd2;
    localparam logic [1:0] c_SEND   = 2'd3;

    localparam logic [7:0] c_CMD_STATUS = 8'h30;
    localparam logic [7:0] c_CMD_MID    = 8'h31;
    localparam logic [7:0] c_CMD_TAIL   = 8'h32;
    localparam logic [7:0] c_CMD_START  = 8'h33;
    localparam logic [7:0] c_CMD_ABORT  = 8'h34;

    localparam logic [7:0] c_RSP_OK     = 8'h4B;  // 'K'
    localparam logic [7:0] c_RSP_ERR    = 8'h45;  // 'E'
    localparam logic [7:0] c_RSP_ABORT  = 8'h41;  // 'A'
    localparam logic [7:0] c_RSP_STATUS = 8'h53;  // 'S'
    localparam logic [7:0] c_RSP_FOUND  = 8'h46;  // 'F'
    localparam logic [7:0] c_RSP_NONE   = 8'h4E;  // 'N'

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [1:0]   r_ret;
    logic         r_busy;
    logic [7:0]   r_cmd;
    logic [15:0]  r_cnt;
    logic [255:0] r_buf;
    logic [39:0]  r_tx_buf;   // response bytes, next byte to send in [39:32]
    logic [2:0]   r_tx_cnt;   // bytes still to send
    logic         r_pend_valid;
    logic         r_pend_found;
    logic [31:0]  r_pend_nonce;
    logic         r_core_start;
    logic         r_core_abort;
    logic [255:0] r_mid;
    logic [95:0]  r_tail;
    logic [31:0]  r_nb;
    logic         w_take;
    logic         w_accept;
    logic         w_last;
    logic         w_result_go;

    // Search result response: 'F' + nonce MSB first, or a lone 'N'.
    function automatic logic [39:0] result_bytes(input logic found, input logic [31:0] nonce);
        return found ? {c_RSP_FOUND, nonce} : {c_RSP_NONE, 32'h0};
    endfunction

    function automatic logic [2:0] result_len(input logic found);
        return found ? 3'd5 : 3'd1;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic, frame acceptance and handshake qualifiers.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_accept     = (r_state == c_SEND) && tx_ready;
        w_last       = w_accept && (r_tx_cnt == 3'd1);
        // A finished search is reported right after the current response.
        w_result_go  = r_pend_valid || (core_done && r_busy);
        case (r_state)
            c_IDLE: begin
                if (ih_ready && !rst) begin
                    w_take       = 1'b1;
                    w_state_next = c_DECODE;
                end
            end
            c_RUN: begin
                // The core result has priority; a waiting frame stays held.
                if (core_done) begin
                    w_state_next = c_SEND;
                end else if (ih_ready && !rst) begin
                    w_take       = 1'b1;
                    w_state_next = c_DECODE;
                end
            end
            c_DECODE: w_state_next = c_SEND;
            c_SEND: begin
                if (w_last) w_state_next = w_result_go ? c_SEND : r_ret;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Frame capture, command execution, job tracking and response shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ret        <= c_IDLE;
            r_busy       <= 1'b0;
            r_cmd        <= 8'h0;
            r_cnt        <= 16'h0;
            r_buf        <= 256'h0;
            r_tx_buf     <= 40'h0;
            r_tx_cnt     <= 3'd0;
            r_pend_valid <= 1'b0;
            r_pend_found <= 1'b0;
            r_pend_nonce <= 32'h0;
            r_core_start <= 1'b0;
            r_core_abort <= 1'b0;
            r_mid        <= 256'h0;
            r_tail       <= 96'h0;
            r_nb         <= 32'h0;
        end else begin
            r_core_start <= 1'b0;
            r_core_abort <= 1'b0;
            if (w_take) begin
                r_cmd <= ih_command;
                r_cnt <= ih_data_count;
                r_buf <= ih_buffer;
            end
            case (r_state)
                c_RUN: begin
                    if (core_done) begin
                        r_tx_buf <= result_bytes(core_found, core_nonce);
                        r_tx_cnt <= result_len(core_found);
                        r_busy   <= 1'b0;
                        r_ret    <= c_IDLE;
                    end
                end
                c_DECODE: begin
                    r_ret    <= r_busy ? c_RUN : c_IDLE;
                    r_tx_buf <= {c_RSP_ERR, 32'h0};
                    r_tx_cnt <= 3'd1;
                    // Abort discards a result that lands on its decode cycle.
                    if (core_done && r_busy && (r_cmd != c_CMD_ABORT)) begin
                        r_pend_valid <= 1'b1;
                        r_pend_found <= core_found;
                        r_pend_nonce <= core_nonce;
                    end
                    case (r_cmd)
                        c_CMD_STATUS: begin
                            r_tx_buf <= {c_RSP_STATUS, 7'b0, r_busy, 24'h0};
                            r_tx_cnt <= 3'd2;
                        end
                        c_CMD_MID: begin
                            if (!r_busy && (r_cnt == 16'd64)) begin
                                r_mid    <= r_buf;
                                r_tx_buf <= {c_RSP_OK, 32'h0};
                            end
                        end
                        c_CMD_TAIL: begin
                            if (!r_busy && (r_cnt == 16'd24)) begin
                                r_tail   <= r_buf[95:0];
                                r_tx_buf <= {c_RSP_OK, 32'h0};
                            end
                        end
                        c_CMD_START: begin
                            if (!r_busy && (r_cnt == 16'd8)) begin
                                r_nb         <= r_buf[31:0];
                                r_core_start <= 1'b1;
                                r_busy       <= 1'b1;
                                r_ret        <= c_RUN;
                                r_tx_buf     <= {c_RSP_OK, 32'h0};
                            end
                        end
                        c_CMD_ABORT: begin
                            if (r_busy) begin
                                r_core_abort <= 1'b1;
                                r_busy       <= 1'b0;
                                r_ret        <= c_IDLE;
                                r_tx_buf     <= {c_RSP_ABORT, 32'h0};
                            end
                        end
                        default: ;
                    endcase
                end
                c_SEND: begin
                    if (w_accept) begin
                        r_tx_buf <= {r_tx_buf[31:0], 8'h00};
                        r_tx_cnt <= r_tx_cnt - 3'd1;
                    end
                    if (w_last && w_result_go) begin
                        if (r_pend_valid) begin
                            r_tx_buf <= result_bytes(r_pend_found, r_pend_nonce);
                            r_tx_cnt <= result_len(r_pend_found);
                        end else begin
                            r_tx_buf <= result_bytes(core_found, core_nonce);
                            r_tx_cnt <= result_len(core_found);
                        end
                        r_pend_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_ret        <= c_IDLE;
                    end else if (core_done && r_busy) begin
                        r_pend_valid <= 1'b1;
                        r_pend_found <= core_found;
                        r_pend_nonce <= core_nonce;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ih_data_request = w_take;
    assign core_start      = r_core_start;
    assign core_abort      = r_core_abort;
    assign core_midstate   = r_mid;
    assign core_tail       = r_tail;
    assign core_nonce_base = r_nb;
    assign tx_valid        = (r_state == c_SEND);
    assign tx_byte         = r_tx_buf[39:32];
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_miner_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_miner_controller
//  Brief    : Self-checking bench: directed scenarios plus random command
//             frames against a transaction-level model with a byte scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_miner_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         ih_ready;
    logic [7:0]   ih_command;
    logic [15:0]  ih_data_count;
    logic [255:0] ih_buffer;
    logic         ih_data_request;
    logic         core_start;
    logic         core_abort;
    logic [255:0] core_midstate;
    logic [95:0]  core_tail;
    logic [31:0]  core_nonce_base;
    logic         core_done;
    logic         core_found;
    logic [31:0]  core_nonce;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         tx_ready;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int rmode = 0;            // 0 random ready, 1 held low, 2 held high
    logic [7:0] exp_q[$];

    // Transaction-level model of the controller's architectural state.
    bit           m_busy;
    logic [255:0] m_mid;
    logic [95:0]  m_tail;
    logic [31:0]  m_nb;

    miner_controller dut (
        .clk(clk), .rst(rst), .ih_ready(ih_ready), .ih_command(ih_command),
        .ih_data_count(ih_data_count), .ih_buffer(ih_buffer),
        .ih_data_request(ih_data_request), .core_start(core_start),
        .core_abort(core_abort), .core_midstate(core_midstate),
        .core_tail(core_tail), .core_nonce_base(core_nonce_base),
        .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Receiver back-pressure.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rmode)
                0:       tx_ready = (($urandom % 4) != 0);
                1:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: every accepted byte must match the queue head.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got %h expected none", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_byte !== e) begin
                        n_err++;
                        $display("FAIL tx_byte: got %h expected %h", tx_byte, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_result(input bit fnd, input logic [31:0] nn);
        if (fnd) begin
            exp_q.push_back(8'h46);
            for (int i = 3; i >= 0; i--) exp_q.push_back(nn[i*8 +: 8]);
        end else begin
            exp_q.push_back(8'h4E);
        end
    endtask

    // Expected effect of one command frame; done_dec = core_done lands on decode.
    task automatic model_frame(input logic [7:0] cmd, input logic [15:0] cnt,
                               input logic [255:0] b, input bit done_dec,
                               input bit fnd, input logic [31:0] nn,
                               output bit e_start, output bit e_abort);
        bit was_busy;
        was_busy = m_busy;
        e_start  = 1'b0;
        e_abort  = 1'b0;
        case (cmd)
            8'h30: begin
                exp_q.push_back(8'h53);
                exp_q.push_back({7'b0, was_busy});
            end
            8'h31: if (!was_busy && cnt == 16'd64) begin m_mid = b; exp_q.push_back(8'h4B); end
                   else exp_q.push_back(8'h45);
            8'h32: if (!was_busy && cnt == 16'd24) begin m_tail = b[95:0]; exp_q.push_back(8'h4B); end
                   else exp_q.push_back(8'h45);
            8'h33: if (!was_busy && cnt == 16'd8) begin
                       m_nb = b[31:0]; m_busy = 1'b1; e_start = 1'b1; exp_q.push_back(8'h4B);
                   end else exp_q.push_back(8'h45);
            8'h34: if (was_busy) begin m_busy = 1'b0; e_abort = 1'b1; exp_q.push_back(8'h41); end
                   else exp_q.push_back(8'h45);
            default: exp_q.push_back(8'h45);
        endcase
        if (done_dec && was_busy && !e_abort) begin
            push_result(fnd, nn);
            m_busy = 1'b0;
        end
    endtask

    // Present one frame as the input handler would; returns in the first
    // response cycle so pulses can be checked.
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] cnt,
                              input logic [255:0] b, input bit done_dec,
                              input bit fnd, input logic [31:0] nn);
        bit ok, e_start, e_abort;
        ok = 1'b0;
        @(posedge clk); #1;
        ih_ready = 1'b1; ih_command = cmd; ih_data_count = cnt; ih_buffer = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ih_data_request) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL frame_request: got no ih_data_request expected pulse (cmd %h)", cmd);
            ih_ready = 1'b0;
        end else begin
            model_frame(cmd, cnt, b, done_dec, fnd, nn, e_start, e_abort);
            @(posedge clk); #1;
            ih_ready = 1'b0;
            chk("request_pulse_width", {255'b0, ih_data_request}, 256'd0);
            if (done_dec) begin core_done = 1'b1; core_found = fnd; core_nonce = nn; end
            @(posedge clk); #1;
            core_done = 1'b0; core_found = 1'b0;
            chk("core_start", {255'b0, core_start}, {255'b0, e_start});
            chk("core_abort", {255'b0, core_abort}, {255'b0, e_abort});
        end
    endtask

    task automatic pulse_done(input bit fnd, input logic [31:0] nn);
        if (m_busy) begin push_result(fnd, nn); m_busy = 1'b0; end
        @(posedge clk); #1;
        core_done = 1'b1; core_found = fnd; core_nonce = nn;
        @(posedge clk); #1;
        core_done = 1'b0; core_found = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_regs();
        chk("core_midstate", core_midstate, m_mid);
        chk("core_tail", {160'b0, core_tail}, {160'b0, m_tail});
        chk("core_nonce_base", {224'b0, core_nonce_base}, {224'b0, m_nb});
        chk("busy", {255'b0, busy}, {255'b0, m_busy});
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx_valid", {255'b0, tx_valid}, 256'd0);
        chk("rst_tx_byte", {248'b0, tx_byte}, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_core_start", {255'b0, core_start}, 256'd0);
        chk("rst_core_abort", {255'b0, core_abort}, 256'd0);
        chk("rst_ih_data_request", {255'b0, ih_data_request}, 256'd0);
        chk("rst_core_midstate", core_midstate, 256'd0);
        chk("rst_core_tail", {160'b0, core_tail}, 256'd0);
        chk("rst_core_nonce_base", {224'b0, core_nonce_base}, 256'd0);
    endtask

    initial begin
        logic [255:0] b;
        logic [15:0]  cnt;
        int           op;
        rst = 1'b1; ih_ready = 1'b1; ih_command = 8'h30; ih_data_count = 16'd0;
        ih_buffer = 256'h0; core_done = 1'b0; core_found = 1'b0; core_nonce = 32'h0;
        m_busy = 1'b0; m_mid = 256'h0; m_tail = 96'h0; m_nb = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        ih_ready = 1'b0;
        rst = 1'b0;

        // Midstate load with a known pattern.
        send_frame(8'h31, 16'd64,
                   256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF,
                   1'b0, 1'b0, 32'h0);
        drain(); check_regs();

        // Wrong length and unknown command both rejected.
        send_frame(8'h31, 16'd63, rand256(), 1'b0, 1'b0, 32'h0);
        drain();
        send_frame(8'h7A, 16'd64, rand256(), 1'b0, 1'b0, 32'h0);
        drain(); check_regs();

        // Job start then golden nonce.
        send_frame(8'h33, 16'd8, 256'h100, 1'b0, 1'b0, 32'h0);
        chk("run_busy", {255'b0, busy}, 256'd1);
        drain(); check_regs();
        pulse_done(1'b1, 32'hDEADBEEF);
        drain(); check_regs();

        // Status request stalled by the receiver while the search completes.
        send_frame(8'h33, 16'd8, 256'h2000, 1'b0, 1'b0, 32'h0);
        drain();
        rmode = 1;
        send_frame(8'h30, 16'd0, 256'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        pulse_done(1'b0, 32'h0);
        chk("busy_pending", {255'b0, busy}, 256'd1);
        repeat (5) @(posedge clk);
        #1;
        rmode = 0;
        drain(); check_regs();

        // Abort decoded on the same cycle the core reports.
        send_frame(8'h33, 16'd8, 256'h3000, 1'b0, 1'b0, 32'h0);
        drain();
        send_frame(8'h34, 16'd0, 256'h0, 1'b1, 1'b1, 32'h55AA55AA);
        drain(); check_regs();

        // Random command mix.
        for (int it = 0; it < 40; it++) begin
            op = $urandom % 8;
            b  = rand256();
            cnt = 16'($urandom_range(0, 80));
            case (op)
                0: send_frame(8'h30, cnt, b, 1'b0, 1'b0, 32'h0);
                1: send_frame(8'h31, ($urandom % 2) ? 16'd64 : cnt, b, 1'b0, 1'b0, 32'h0);
                2: send_frame(8'h32, ($urandom % 2) ? 16'd24 : cnt, b, 1'b0, 1'b0, 32'h0);
                3: send_frame(8'h33, ($urandom % 3) ? 16'd8 : cnt, b, 1'b0, 1'b0, 32'h0);
                4: send_frame(8'h34, cnt, b, 1'b0, 1'b0, 32'h0);
                5: send_frame(8'($urandom), cnt, b, 1'b0, 1'b0, 32'h0);
                6: pulse_done(1'($urandom % 2), $urandom);
                default: send_frame(8'h30 + 8'($urandom % 5), 16'd8, b, 1'b1,
                                    1'($urandom % 2), $urandom);
            endcase
            drain(); check_regs();
        end

        // Reset in the middle of a found-nonce response.
        if (!m_busy) begin
            send_frame(8'h33, 16'd8, 256'h4000, 1'b0, 1'b0, 32'h0);
            drain();
        end
        rmode = 1;
        pulse_done(1'b1, 32'hCAFEF00D);
        rmode = 2;
        @(posedge clk);
        @(posedge clk); #1;
        rmode = 1;
        chk("mid_response_byte", {248'b0, tx_byte}, {248'b0, 8'hFE});
        chk("mid_response_left", exp_q.size(), 256'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        rst = 1'b0;
        exp_q.delete();
        m_busy = 1'b0; m_mid = 256'h0; m_tail = 96'h0; m_nb = 32'h0;
        rmode = 0;
        send_frame(8'h30, 16'd0, 256'h0, 1'b0, 1'b0, 32'h0);
        drain(); check_regs();
        chk("queue_empty", exp_q.size(), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/miner_controller.md
MINER_CONTROLLER -- requirements
Module: miner_controller

Interface
REQ-001 clk  input  1  single system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 ih_ready  input  1  input_handler holds a complete frame (level).
REQ-004 ih_command  input  8  ASCII command byte of held frame.
REQ-005 ih_data_count  input  16  number of hex nibbles received in held frame.
REQ-006 ih_buffer  input  256  frame payload, last nibble received in bits [3:0].
REQ-007 ih_data_request  output  1  one-cycle pulse; releases held frame in input_handler.
REQ-008 core_start  output  1  one-cycle pulse; launches hash core.
REQ-009 core_abort  output  1  one-cycle pulse; stops hash core.
REQ-010 core_midstate  output  256  midstate register; stable while core runs.
REQ-011 core_tail  output  96  block-tail register; stable while core runs.
REQ-012 core_nonce_base  output  32  first nonce to try.
REQ-013 core_done  input  1  one-cycle pulse; search finished.
REQ-014 core_found  input  1  valid with core_done; 1 = golden nonce found.
REQ-015 core_nonce  input  32  valid with core_done when core_found=1.
REQ-016 tx_valid / tx_byte  output  1 / 8  response byte stream; held until accepted.
REQ-017 tx_ready  input  1  byte accepted when tx_valid and tx_ready both high.
REQ-018 busy  output  1  high while a job is running (RUN state, including nested SEND).

Function
REQ-019 States: IDLE, DECODE, RUN, SEND; return-state register selects IDLE or RUN after SEND.
REQ-020 IDLE or RUN with ih_ready=1 and SEND not active -> pulse ih_data_request same cycle frame is captured, go DECODE; ih_ready ignored for the cycle after the pulse.
REQ-021 Command '1' (0x31): ih_data_count==64 -> load core_midstate<=ih_buffer, respond 'K'; else respond 'E'.
REQ-022 Command '2' (0x32): ih_data_count==24 -> core_tail<=ih_buffer[95:0], respond 'K'; else 'E'.
REQ-023 Command '3' (0x33): ih_data_count==8 and not busy -> core_nonce_base<=ih_buffer[31:0], pulse core_start, enter RUN, respond 'K'; otherwise 'E'.
REQ-024 Command '4' (0x34): in RUN -> pulse core_abort, busy<=0, respond 'A', return IDLE; in IDLE respond 'E'.
REQ-025 Command '0' (0x30): respond 'S' then one status byte {7'b0, busy}; returns to originating state.
REQ-026 Any other command, or '1'/'2' while busy -> respond 'E', state and registers unchanged.
REQ-027 core_done in RUN: found -> respond 'F' + core_nonce as 4 bytes MSB first; not found -> respond 'N'; then IDLE, busy<=0.
REQ-028 core_done arriving during SEND nested in RUN: latch result in one-entry pending register; report immediately after current response completes.
REQ-029 core_done coincident with abort decode: abort wins, result discarded, response 'A' only.
REQ-030 core_done outside RUN ignored.
REQ-031 SEND: tx_byte stable while tx_valid high; next byte presented cycle after acceptance; tx_ready may stay high continuously (one byte per cycle).
REQ-032 Decode-to-first-tx_valid latency: exactly 1 cycle after DECODE.
REQ-033 Responses never interleave; a second frame waits in input_handler (ih_ready high) until SEND completes.

Reset
REQ-034 rst=1 for any cycle -> state IDLE, all pulses 0, tx_valid=0, tx_byte=0, busy=0, pending cleared, core_midstate/core_tail/core_nonce_base=0.
REQ-035 Reset mid-RUN or mid-SEND: no core_abort pulse issued; partial response discarded.

Verification
REQ-036 Frame '1', count 64, buffer 0x0123...EF -> one ih_data_request pulse, core_midstate=buffer, tx 'K' (0x4B).
REQ-037 Frame '3', count 8, buffer[31:0]=0x00000100 -> core_start pulse, core_nonce_base=0x100, busy=1, tx 'K'; then core_done,found=1,nonce=0xDEADBEEF -> tx 0x46,0xDE,0xAD,0xBE,0xEF, busy=0.
REQ-038 During RUN send '0' with tx_ready held low 10 cycles, core_done (found=0) fires in that window -> tx 'S',0x01 then 'N'.
REQ-039 During RUN send '4' with core_done same cycle as decode -> core_abort pulse, tx 'A' only, IDLE.
REQ-040 Frame '1' count 63, then frame 0x7A -> tx 'E','E', midstate unchanged.
REQ-041 Assert rst during 'F' response after second byte -> tx_valid=0 next cycle, all outputs at reset values.
